// File: rtl/instr_register_pipe_if.sv
// rtl/instr_register_pipe_if.sv - instruction load handshake and register-file read bus
interface instr_register_pipe_if #(
    parameter int OP_W  = 32,
    parameter int PTR_W = 5
);
    localparam int RES_W = 2 * OP_W;
    localparam int IW    = 4 + 2 * OP_W + RES_W + 2;

    logic             load_valid;
    logic             load_ready;
    logic [3:0]       opcode;
    logic [OP_W-1:0]  operand_a;
    logic [OP_W-1:0]  operand_b;
    logic [PTR_W-1:0] write_pointer;
    logic [PTR_W-1:0] read_pointer;
    logic [IW-1:0]    instruction_word;
    logic [PTR_W:0]   valid_count;
    logic             busy;

    modport master (
        output load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  load_ready, instruction_word, valid_count, busy
    );

    modport slave (
        input  load_valid, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output load_ready, instruction_word, valid_count, busy
    );
endinterface

// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - instruction executor with result register file
module instr_register_pipe #(
    parameter int OP_W    = 32,
    parameter int DEPTH   = 32,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int MAX_EXP = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_register_pipe_if.slave  bus
);
    localparam int RES_W   = 2 * OP_W;
    localparam int ENTRY_W = 4 + 2 * OP_W + RES_W + 2;
    localparam int CNT_W   = $clog2(MAX_EXP + 1);

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;
    localparam logic [3:0] OPC_POW   = 4'd8;

    typedef enum logic [1:0] {IDLE, EXEC, ITER} state_e;

    state_e                   state_q;
    logic                     ready_q;
    logic [3:0]               opc_q;
    logic [OP_W-1:0]          a_q;
    logic [OP_W-1:0]          b_q;
    logic [PTR_W-1:0]         ptr_q;
    logic signed [RES_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [ENTRY_W-1:0]       mem_q [DEPTH];
    logic [PTR_W:0]           count_q;

    logic                     in_a_zero;
    logic                     in_b_neg;
    logic                     in_b_zero;
    logic                     in_b_big;
    logic                     start_iter;

    logic signed [RES_W-1:0]  a_ext;
    logic signed [RES_W-1:0]  b_ext;
    logic                     b_zero;
    logic                     b_neg;
    logic                     b_big;
    logic signed [RES_W-1:0]  exec_res;
    logic                     exec_err;
    logic signed [RES_W-1:0]  acc_d;
    logic                     wr_en;
    logic [RES_W-1:0]         wr_res;
    logic                     wr_err;

    // Only a POW with a non-trivial exponent in range needs the iterative path.
    assign in_a_zero  = (bus.operand_a == '0);
    assign in_b_neg   = bus.operand_b[OP_W-1];
    assign in_b_zero  = (bus.operand_b == '0);
    assign in_b_big   = !in_b_neg && (bus.operand_b > OP_W'(MAX_EXP));
    assign start_iter = (bus.opcode == OPC_POW) && !in_a_zero && !in_b_neg
                        && !in_b_zero && !in_b_big;

    assign a_ext  = {{OP_W{a_q[OP_W-1]}}, a_q};
    assign b_ext  = {{OP_W{b_q[OP_W-1]}}, b_q};
    assign b_zero = (b_q == '0);
    assign b_neg  = b_q[OP_W-1];
    assign b_big  = !b_neg && (b_q > OP_W'(MAX_EXP));
    assign acc_d  = acc_q * a_ext;

    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        case (opc_q)
            OPC_ZERO:  exec_res = '0;
            OPC_PASSA: exec_res = a_ext;
            OPC_PASSB: exec_res = b_ext;
            OPC_ADD:   exec_res = a_ext + b_ext;
            OPC_SUB:   exec_res = a_ext - b_ext;
            OPC_MULT:  exec_res = a_ext * b_ext;
            OPC_DIV: begin
                if (b_zero) exec_err = 1'b1;
                else        exec_res = a_ext / b_ext;
            end
            OPC_MOD: begin
                if (b_zero) exec_err = 1'b1;
                else        exec_res = a_ext % b_ext;
            end
            OPC_POW: begin
                // Reaching EXEC with a legal exponent means a==0 or b==0.
                if (b_neg || b_big)  exec_err = 1'b1;
                else if (a_q != '0)  exec_res = RES_W'(1);
                else                 exec_res = '0;
            end
            default:   exec_err = 1'b1;
        endcase
    end

    always_comb begin
        wr_en  = (state_q == EXEC) || ((state_q == ITER) && (cnt_q == CNT_W'(1)));
        wr_res = (state_q == ITER) ? acc_d : exec_res;
        wr_err = (state_q == ITER) ? 1'b0 : exec_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ptr_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        opc_q   <= bus.opcode;
                        a_q     <= bus.operand_a;
                        b_q     <= bus.operand_b;
                        ptr_q   <= bus.write_pointer;
                        acc_q   <= RES_W'(1);
                        cnt_q   <= bus.operand_b[CNT_W-1:0];
                        state_q <= start_iter ? ITER : EXEC;
                        ready_q <= 1'b0;
                    end
                end
                EXEC: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                ITER: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase

            if (wr_en) begin
                mem_q[ptr_q] <= {opc_q, a_q, b_q, wr_res, wr_err, 1'b1};
                if (!mem_q[ptr_q][0]) count_q <= count_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    assign bus.load_ready       = ready_q;
    assign bus.busy             = !ready_q;
    assign bus.valid_count      = count_q;
    assign bus.instruction_word = mem_q[bus.read_pointer];
endmodule
